// File: rtl/tetris_pkg.sv
// Shared board geometry, cell layout and fetch FSM state encoding.
package tetris_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;

    // One board cell: flags in the top nibble, RGB444 color below.
    typedef logic [15:0] cell_t;

    localparam int CELL_RGB_LSB   = 0;
    localparam int CELL_RGB_W     = 12;
    localparam int CELL_FLAGS_LSB = 12;
    localparam int CELL_FLAGS_W   = 4;

    // Flag nibble stamped on cells that belong to the falling piece.
    localparam logic [3:0] PIECE_FLAG = 4'h1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    // Assemble a cell from its flag nibble and color.
    function automatic cell_t make_cell(input logic [3:0] flags, input logic [11:0] rgb);
        return {flags, rgb};
    endfunction

endpackage

// File: rtl/board_row_fetch_piece_hit.sv
// Combinational test: does any of the four piece blocks sit on (col, row)?
import tetris_pkg::*;

module piece_hit (
    input  logic [3:0] col,
    input  logic [7:0] row,
    input  logic       piece_valid,
    input  logic [3:0] piece_x [4],
    input  logic [4:0] piece_y [4],
    output logic       hit
);

    logic [3:0] block_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_block
            assign block_hit[gi] = (piece_x[gi] == col) && ({3'b000, piece_y[gi]} == row);
        end
    endgenerate

    assign hit = piece_valid & (|block_hit);

endmodule

// File: rtl/board_row_fetch.sv
// Fetches one board row from the synchronous board RAM, overlays the
// latched falling piece, and publishes the assembled row with a strobe.
import tetris_pkg::*;

module board_row_fetch #(
    parameter int BOARD_W = tetris_pkg::BOARD_W,
    parameter int BOARD_H = tetris_pkg::BOARD_H
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        LD_Row,
    input  logic [7:0]  rowNum,
    output logic [7:0]  mem_addr,
    output logic        mem_rd_en,
    input  logic [15:0] mem_rdata,
    input  logic        piece_valid,
    input  logic [3:0]  piece_x [4],
    input  logic [4:0]  piece_y [4],
    input  logic [11:0] piece_color,
    output cell_t       Row [BOARD_W],
    output logic        rowReady,
    output logic        busy,
    output logic        overrun
);

    localparam logic [3:0] LAST_COL = 4'(BOARD_W - 1);

    fetch_state_t state_q, state_d;
    logic [3:0]   col_q, col_d;
    logic [7:0]   row_q, row_d;
    logic [3:0]   px_q [4];
    logic [3:0]   px_d [4];
    logic [4:0]   py_q [4];
    logic [4:0]   py_d [4];
    logic [11:0]  pcolor_q, pcolor_d;
    logic         pvalid_q, pvalid_d;
    cell_t        shadow_q [BOARD_W];
    cell_t        shadow_d [BOARD_W];
    cell_t        row_out_q [BOARD_W];
    cell_t        row_out_d [BOARD_W];
    logic         row_ready_q, row_ready_d;
    logic         overrun_q, overrun_d;
    logic         ld_prev_q, ld_prev_d;

    logic         request;
    logic [3:0]   cap_col;
    logic         cap_hit;
    cell_t        cap_cell;

    // Only the rising edge of the request level starts a fetch.
    assign request = LD_Row & ~ld_prev_q;

    // RAM data lags the address by one cycle, so the cell being captured is
    // one column behind the address; in DRAIN it is the last column.
    assign cap_col = (state_q == ST_DRAIN) ? LAST_COL : 4'(col_q - 4'd1);

    piece_hit u_piece_hit (
        .col         (cap_col),
        .row         (row_q),
        .piece_valid (pvalid_q),
        .piece_x     (px_q),
        .piece_y     (py_q),
        .hit         (cap_hit)
    );

    assign cap_cell = cap_hit ? make_cell(PIECE_FLAG, pcolor_q) : cell_t'(mem_rdata);

    // RAM address and enable follow state, row and column directly.
    always_comb begin
        mem_rd_en = 1'b0;
        mem_addr  = 8'd0;
        if (state_q == ST_FETCH) begin
            mem_rd_en = 1'b1;
            mem_addr  = 8'(row_q * 8'(BOARD_W)) + {4'b0000, col_q};
        end
    end

    // Next-state logic: edge detect, fetch sequencing, capture and publish.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        px_d        = px_q;
        py_d        = py_q;
        pcolor_d    = pcolor_q;
        pvalid_d    = pvalid_q;
        shadow_d    = shadow_q;
        row_out_d   = row_out_q;
        row_ready_d = 1'b0;
        overrun_d   = overrun_q;
        ld_prev_d   = LD_Row;

        case (state_q)
            ST_IDLE: begin
                if (request) begin
                    if (rowNum < 8'(BOARD_H)) begin
                        // Latch the piece so a move mid-fetch cannot tear the row.
                        row_d    = rowNum;
                        px_d     = piece_x;
                        py_d     = piece_y;
                        pcolor_d = piece_color;
                        pvalid_d = piece_valid;
                        col_d    = 4'd0;
                        state_d  = ST_FETCH;
                    end else begin
                        // Off-board rows are drawn blank without touching RAM.
                        for (int i = 0; i < BOARD_W; i++) begin
                            row_out_d[i] = '0;
                        end
                        row_ready_d = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (col_q != 4'd0) begin
                    shadow_d[cap_col] = cap_cell;
                end
                if (col_q == LAST_COL) begin
                    col_d   = 4'd0;
                    state_d = ST_DRAIN;
                end else begin
                    col_d = col_q + 4'd1;
                end
            end
            ST_DRAIN: begin
                shadow_d[LAST_COL] = cap_cell;
                row_out_d          = shadow_d;
                row_ready_d        = 1'b1;
                state_d            = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new request while busy is dropped but remembered.
        if (request && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // State registers; reset aborts any fetch and blanks the published row.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            col_q       <= 4'd0;
            row_q       <= 8'd0;
            pcolor_q    <= 12'd0;
            pvalid_q    <= 1'b0;
            row_ready_q <= 1'b0;
            overrun_q   <= 1'b0;
            ld_prev_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                px_q[i] <= 4'd0;
                py_q[i] <= 5'd0;
            end
            for (int i = 0; i < BOARD_W; i++) begin
                shadow_q[i]  <= '0;
                row_out_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            px_q        <= px_d;
            py_q        <= py_d;
            pcolor_q    <= pcolor_d;
            pvalid_q    <= pvalid_d;
            shadow_q    <= shadow_d;
            row_out_q   <= row_out_d;
            row_ready_q <= row_ready_d;
            overrun_q   <= overrun_d;
            ld_prev_q   <= ld_prev_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BOARD_W; gi++) begin : g_row_out
            assign Row[gi] = row_out_q[gi];
        end
    endgenerate

    assign rowReady = row_ready_q;
    assign busy     = (state_q != ST_IDLE);
    assign overrun  = overrun_q;

endmodule
